// File: rtl/mor1kx_rf_mp_pkg.sv
// Shared types and helpers for the multi-port MAROCCHINO register file.
// SPR FSM state encoding, GPR window constant, bank index width helper.
package mor1kx_rf_mp_pkg;

    typedef enum logic [1:0] {
        SPR_IDLE = 2'd0,
        SPR_RD   = 2'd1,
        SPR_ACK  = 2'd2
    } spr_state_t;

    localparam logic [6:0] GPR_WINDOW = 7'h2;

    // A single bank still gets a 1-bit context select.
    function automatic int bank_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/mor1kx_rf_bypass_port.sv
// One decode read port: registered RAM read, write-first on fetch, and a hold
// register that tracks later write-backs to the address held in decode.
module mor1kx_rf_bypass_port #(
    parameter int W  = 32,
    parameter int P  = 2,
    parameter int IW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 fetch_vld,
    input  logic [IW-1:0]        fetch_idx,
    input  logic [W-1:0]         mem_rd,
    input  logic [P-1:0]         we,
    input  logic [P-1:0][IW-1:0] wb_idx,
    input  logic [P-1:0][W-1:0]  wb_dat,
    output logic [W-1:0]         dat
);

    logic [IW-1:0] idx_q;
    logic          vld_q;
    logic          hold_q;
    logic [W-1:0]  ram_q;
    logic [W-1:0]  hold_dat_q;

    logic          fetch_hit;
    logic          held_hit;
    logic [W-1:0]  fetch_wdat;
    logic [W-1:0]  held_wdat;

    // Ascending scan: the highest-numbered matching channel wins.
    always_comb begin
        fetch_hit  = 1'b0;
        held_hit   = 1'b0;
        fetch_wdat = '0;
        held_wdat  = '0;
        for (int k = 0; k < P; k++) begin
            if (we[k] && (wb_idx[k] == fetch_idx)) begin
                fetch_hit  = 1'b1;
                fetch_wdat = wb_dat[k];
            end
            if (we[k] && vld_q && (wb_idx[k] == idx_q)) begin
                held_hit  = 1'b1;
                held_wdat = wb_dat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            vld_q      <= 1'b0;
            hold_q     <= 1'b0;
            ram_q      <= '0;
            hold_dat_q <= '0;
        end else if (fetch_vld) begin
            idx_q      <= fetch_idx;
            vld_q      <= 1'b1;
            ram_q      <= mem_rd;
            hold_q     <= fetch_hit;
            hold_dat_q <= fetch_wdat;
        end else if (flush) begin
            hold_q     <= 1'b0;
        end else if (held_hit) begin
            hold_q     <= 1'b1;
            hold_dat_q <= held_wdat;
        end
    end

    assign dat = held_hit ? held_wdat :
                 hold_q   ? hold_dat_q : ram_q;

endmodule

// File: rtl/mor1kx_rf_mp_marocchino.sv
// Multi-port GPR file with per-port write-back bypass and optional SPR access
// window (enabled by defining MOR1KX_RF_SPR_ACCESS_EN).
module mor1kx_rf_mp_marocchino
    import mor1kx_rf_mp_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int NUM_RD_PORTS             = 2,
    parameter int NUM_WB_PORTS             = 2,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 padv_decode_i,
    input  logic                                                 pipeline_flush_i,
    input  logic                                                 fetch_rf_adr_valid_i,
    input  logic [NUM_RD_PORTS*OPTION_RF_ADDR_WIDTH-1:0]         fetch_rf_adr_i,
    input  logic [bank_bits(OPTION_RF_NUM_SHADOW_GPR+1)-1:0]     ctx_i,
    input  logic [NUM_WB_PORTS-1:0]                              wb_we_i,
    input  logic [NUM_WB_PORTS*OPTION_RF_ADDR_WIDTH-1:0]         wb_adr_i,
    input  logic [NUM_WB_PORTS*OPTION_OPERAND_WIDTH-1:0]         wb_dat_i,
    input  logic [15:0]                                          spr_bus_addr_i,
    input  logic                                                 spr_bus_stb_i,
    input  logic                                                 spr_bus_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]                      spr_bus_dat_i,
    output logic                                                 spr_gpr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]                      spr_gpr_dat_o,
    output logic [NUM_RD_PORTS*OPTION_OPERAND_WIDTH-1:0]         dcod_rf_dat_o
);

    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int A     = OPTION_RF_ADDR_WIDTH;
    localparam int R     = NUM_RD_PORTS;
    localparam int P     = NUM_WB_PORTS;
    localparam int B     = OPTION_RF_NUM_SHADOW_GPR + 1;
    localparam int BW    = bank_bits(B);
    localparam int IW    = (B > 1) ? (BW + A) : A;
    localparam int DEPTH = B << A;

    // Flat word index {bank, gpr}; the bank field vanishes with one bank.
    function automatic logic [IW-1:0] mk_idx(input logic [BW-1:0] b, input logic [A-1:0] a);
        return IW'({b, a});
    endfunction

    logic [W-1:0]          mem [DEPTH];
    logic [BW-1:0]         ctx_bank;
    logic [P-1:0]          wb_we;
    logic [P-1:0][IW-1:0]  wb_idx;
    logic [P-1:0][W-1:0]   wb_dat;
    logic [R-1:0][W-1:0]   port_dat;
    logic                  spr_we;
    logic [IW-1:0]         spr_idx;
    logic                  unused_bits;

    assign ctx_bank = (B > 1) ? ctx_i : '0;
    assign wb_we    = wb_we_i & {P{~pipeline_flush_i}};
    assign wb_dat   = wb_dat_i;

    always_comb begin
        for (int k = 0; k < P; k++)
            wb_idx[k] = mk_idx(ctx_bank, wb_adr_i[k*A +: A]);
    end

    // SPR writes never collide with write-back: the FSM defers them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < P; k++)
            if (wb_we[k])
                mem[wb_idx[k]] <= wb_dat[k];
        if (spr_we)
            mem[spr_idx] <= spr_bus_dat_i;
    end

    for (genvar r = 0; r < R; r++) begin : g_port
        logic [IW-1:0] f_idx;
        assign f_idx = mk_idx(ctx_bank, fetch_rf_adr_i[r*A +: A]);

        mor1kx_rf_bypass_port #(
            .W  (W),
            .P  (P),
            .IW (IW)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (pipeline_flush_i),
            .fetch_vld (fetch_rf_adr_valid_i),
            .fetch_idx (f_idx),
            .mem_rd    (mem[f_idx]),
            .we        (wb_we),
            .wb_idx    (wb_idx),
            .wb_dat    (wb_dat),
            .dat       (port_dat[r])
        );
    end

    assign dcod_rf_dat_o = port_dat;

`ifdef MOR1KX_RF_SPR_ACCESS_EN
    spr_state_t    state;
    spr_state_t    state_nxt;
    logic          win;
    logic [W-1:0]  spr_dat_q;

    assign win     = spr_bus_stb_i && (spr_bus_addr_i[15:9] == GPR_WINDOW);
    assign spr_idx = mk_idx((B > 1) ? spr_bus_addr_i[A+BW-1:A] : '0, spr_bus_addr_i[A-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SPR_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SPR_IDLE: if (win && !spr_bus_we_i) state_nxt = SPR_RD;
            SPR_RD:   state_nxt = spr_bus_stb_i ? SPR_ACK : SPR_IDLE;
            SPR_ACK:  state_nxt = SPR_IDLE;
            default:  state_nxt = SPR_IDLE;
        endcase
    end

    always_comb begin
        spr_we        = (state == SPR_IDLE) && win && spr_bus_we_i && !(|wb_we_i);
        spr_gpr_ack_o = spr_we || ((state == SPR_ACK) && spr_bus_stb_i);
        spr_gpr_dat_o = ((state == SPR_ACK) && spr_bus_stb_i) ? spr_dat_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spr_dat_q <= '0;
        else if ((state == SPR_RD) && spr_bus_stb_i)
            spr_dat_q <= mem[spr_idx];
    end
`else
    assign spr_we        = 1'b0;
    assign spr_idx       = '0;
    assign spr_gpr_ack_o = 1'b1;
    assign spr_gpr_dat_o = '0;
`endif

    assign unused_bits = ^{padv_decode_i, ctx_i, spr_bus_addr_i, spr_bus_stb_i,
                           spr_bus_we_i, spr_bus_dat_i};

endmodule

// File: tb/tb_mor1kx_rf_mp_marocchino.sv
// Self-checking bench: directed hazard/SPR cases plus random traffic against an
// architectural register-array model.
module tb_mor1kx_rf_mp_marocchino;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        padv_decode_i, pipeline_flush_i, fetch_rf_adr_valid_i;
    logic [9:0]  fetch_rf_adr_i;
    logic [0:0]  ctx_i;
    logic [1:0]  wb_we_i;
    logic [9:0]  wb_adr_i;
    logic [63:0] wb_dat_i;
    logic [15:0] spr_bus_addr_i;
    logic        spr_bus_stb_i, spr_bus_we_i;
    logic [31:0] spr_bus_dat_i;
    logic        spr_gpr_ack_o;
    logic [31:0] spr_gpr_dat_o;
    logic [63:0] dcod_rf_dat_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] mm [32];
    int held [2];

`ifdef MOR1KX_RF_SPR_ACCESS_EN
    localparam logic ACK_IDLE = 1'b0;
`else
    localparam logic ACK_IDLE = 1'b1;
`endif

    mor1kx_rf_mp_marocchino dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .padv_decode_i        (padv_decode_i),
        .pipeline_flush_i     (pipeline_flush_i),
        .fetch_rf_adr_valid_i (fetch_rf_adr_valid_i),
        .fetch_rf_adr_i       (fetch_rf_adr_i),
        .ctx_i                (ctx_i),
        .wb_we_i              (wb_we_i),
        .wb_adr_i             (wb_adr_i),
        .wb_dat_i             (wb_dat_i),
        .spr_bus_addr_i       (spr_bus_addr_i),
        .spr_bus_stb_i        (spr_bus_stb_i),
        .spr_bus_we_i         (spr_bus_we_i),
        .spr_bus_dat_i        (spr_bus_dat_i),
        .spr_gpr_ack_o        (spr_gpr_ack_o),
        .spr_gpr_dat_o        (spr_gpr_dat_o),
        .dcod_rf_dat_o        (dcod_rf_dat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_port(input int p);
        return (held[p] < 0) ? 32'h0 : mm[held[p]];
    endfunction

    // One clock: drive, update the architectural model at the edge, check both ports.
    task automatic step(input logic fv, input logic [4:0] f0, input logic [4:0] f1,
                        input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic fl);
        fetch_rf_adr_valid_i = fv;
        padv_decode_i        = fv;
        fetch_rf_adr_i       = {f1, f0};
        wb_we_i              = we;
        wb_adr_i             = {a1, a0};
        wb_dat_i             = {d1, d0};
        pipeline_flush_i     = fl;
        @(posedge clk);
        if (!fl) begin
            if (we[0]) mm[a0] = d0;
            if (we[1]) mm[a1] = d1;
        end
        if (fv) begin
            held[0] = int'(f0);
            held[1] = int'(f1);
        end
        #1;
        chk("port0_model", dcod_rf_dat_o[31:0],  exp_port(0));
        chk("port1_model", dcod_rf_dat_o[63:32], exp_port(1));
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        padv_decode_i = 1'b0; pipeline_flush_i = 1'b0; fetch_rf_adr_valid_i = 1'b0;
        fetch_rf_adr_i = '0; ctx_i = '0; wb_we_i = '0; wb_adr_i = '0; wb_dat_i = '0;
        spr_bus_addr_i = '0; spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0; spr_bus_dat_i = '0;
        held[0] = -1; held[1] = -1;
        #12;
        chk("reset_port0", dcod_rf_dat_o[31:0],  32'h0);
        chk("reset_port1", dcod_rf_dat_o[63:32], 32'h0);
        chk("reset_ack",   {31'h0, spr_gpr_ack_o}, {31'h0, ACK_IDLE});
        chk("reset_sprdat", spr_gpr_dat_o, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step(1'b0, 5'd0, 5'd0, 2'b11, 5'(2*i), 5'(2*i+1), $urandom, $urandom, 1'b0);

        // write, then fetch next cycle
        step(1'b0, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h1234, 32'h0, 1'b0);
        step(1'b1, 5'd3, 5'd1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("wr_then_fetch", dcod_rf_dat_o[31:0], 32'h1234);
        // fetch and write in the same cycle
        step(1'b1, 5'd5, 5'd2, 2'b10, 5'd0, 5'd5, 32'h0, 32'hBEEF, 1'b0);
        chk("fetch_wb_hazard", dcod_rf_dat_o[31:0], 32'hBEEF);
        // both channels to the same register
        step(1'b0, 5'd0, 5'd0, 2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 1'b0);
        step(1'b1, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("same_adr_ch1_wins", dcod_rf_dat_o[31:0], 32'h2);
        // later write to a held address
        step(1'b1, 5'd4, 5'd6, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        idle();
        step(1'b0, 5'd0, 5'd0, 2'b01, 5'd4, 5'd0, 32'hAA, 32'h0, 1'b0);
        chk("hold_capture", dcod_rf_dat_o[31:0], 32'hAA);
        idle();
        chk("hold_keeps", dcod_rf_dat_o[31:0], 32'hAA);
        // flushed write must not land
        step(1'b1, 5'd4, 5'd4, 2'b01, 5'd4, 5'd0, 32'h77, 32'h0, 1'b1);
        chk("flush_blocks_wb", dcod_rf_dat_o[31:0], 32'hAA);
        step(1'b1, 5'd1, 5'd2, 2'b01, 5'd5, 5'd0, 32'h55, 32'h0, 1'b0);

`ifdef MOR1KX_RF_SPR_ACCESS_EN
        spr_bus_addr_i = 16'h0405; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
        #1 chk("spr_rd_ack_c0", {31'h0, spr_gpr_ack_o}, 32'h0);
        idle();
        chk("spr_rd_ack_c1", {31'h0, spr_gpr_ack_o}, 32'h0);
        idle();
        chk("spr_rd_ack_c2", {31'h0, spr_gpr_ack_o}, 32'h1);
        chk("spr_rd_dat", spr_gpr_dat_o, 32'h55);
        spr_bus_stb_i = 1'b0;
        #1 chk("spr_rd_done_dat", spr_gpr_dat_o, 32'h0);

        spr_bus_addr_i = 16'h0409; spr_bus_we_i = 1'b1; spr_bus_dat_i = 32'h99; spr_bus_stb_i = 1'b1;
        #1 chk("spr_wr_ack", {31'h0, spr_gpr_ack_o}, 32'h1);
        idle();
        mm[9] = 32'h99;
        spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;
        step(1'b1, 5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("spr_wr_visible", dcod_rf_dat_o[31:0], 32'h99);

        step(1'b1, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        spr_bus_addr_i = 16'h040A; spr_bus_we_i = 1'b1; spr_bus_dat_i = 32'hA0A0; spr_bus_stb_i = 1'b1;
        wb_we_i = 2'b01; wb_adr_i = {5'd0, 5'd11}; wb_dat_i = {32'h0, 32'h1111};
        #1 chk("spr_wr_deferred", {31'h0, spr_gpr_ack_o}, 32'h0);
        step(1'b0, 5'd0, 5'd0, 2'b01, 5'd11, 5'd0, 32'h1111, 32'h0, 1'b0);
        wb_we_i = 2'b00;
        #1 chk("spr_wr_retry_ack", {31'h0, spr_gpr_ack_o}, 32'h1);
        idle();
        mm[10] = 32'hA0A0;
        spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;
        step(1'b1, 5'd10, 5'd11, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("spr_deferred_wr", dcod_rf_dat_o[31:0], 32'hA0A0);
        chk("wb_during_defer", dcod_rf_dat_o[63:32], 32'h1111);
        step(1'b1, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);

        spr_bus_addr_i = 16'h0805; spr_bus_stb_i = 1'b1;
        idle(); idle();
        chk("nonwin_ack", {31'h0, spr_gpr_ack_o}, 32'h0);
        chk("nonwin_dat", spr_gpr_dat_o, 32'h0);
        spr_bus_stb_i = 1'b0;

        spr_bus_addr_i = 16'h0405; spr_bus_stb_i = 1'b1;
        idle();
        spr_bus_stb_i = 1'b0;
        idle();
        chk("stb_drop_ack1", {31'h0, spr_gpr_ack_o}, 32'h0);
        idle();
        chk("stb_drop_ack2", {31'h0, spr_gpr_ack_o}, 32'h0);

        spr_bus_stb_i = 1'b1;
        idle();
        rst_n = 1'b0;
        #1;
        held[0] = -1; held[1] = -1;
        chk("rst_rd_ack", {31'h0, spr_gpr_ack_o}, 32'h0);
        chk("rst_rd_dat", spr_gpr_dat_o, 32'h0);
        chk("rst_rd_port0", dcod_rf_dat_o[31:0], 32'h0);
        chk("rst_rd_port1", dcod_rf_dat_o[63:32], 32'h0);
        spr_bus_stb_i = 1'b0;
        #2 rst_n = 1'b1;
        idle();
        chk("post_rst_ack1", {31'h0, spr_gpr_ack_o}, 32'h0);
        idle();
        chk("post_rst_ack2", {31'h0, spr_gpr_ack_o}, 32'h0);
        step(1'b1, 5'd5, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("ram_survives_rst", dcod_rf_dat_o[31:0], 32'h55);
`else
        spr_bus_addr_i = 16'h0409; spr_bus_we_i = 1'b1; spr_bus_dat_i = 32'hDEAD; spr_bus_stb_i = 1'b1;
        #1 chk("spr_off_ack", {31'h0, spr_gpr_ack_o}, 32'h1);
        chk("spr_off_dat", spr_gpr_dat_o, 32'h0);
        idle();
        spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;
        step(1'b1, 5'd9, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("spr_off_port1", dcod_rf_dat_o[63:32], 32'h55);
        rst_n = 1'b0;
        #1;
        held[0] = -1; held[1] = -1;
        chk("rst_port0", dcod_rf_dat_o[31:0], 32'h0);
        #2 rst_n = 1'b1;
        step(1'b1, 5'd5, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("ram_survives_rst", dcod_rf_dat_o[31:0], 32'h55);
`endif

        for (int i = 0; i < 400; i++) begin
            logic       fv, fl;
            logic [4:0] a0, a1;
            fl = ($urandom_range(0, 15) == 0);
            fv = fl | 1'($urandom_range(0, 1));
            a0 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            step(fv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), a0, a1, $urandom, $urandom, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
